// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display path and its capture observer.
// Segment patterns are ordered a..g, MSB = a.
package seg_pkg;

   localparam int SEG_DP_BIT = 0;

   localparam logic [6:0] SEG_0 = 7'b1111110;
   localparam logic [6:0] SEG_1 = 7'b0110000;
   localparam logic [6:0] SEG_2 = 7'b1101101;
   localparam logic [6:0] SEG_3 = 7'b1111001;
   localparam logic [6:0] SEG_4 = 7'b0110011;
   localparam logic [6:0] SEG_5 = 7'b1011011;
   localparam logic [6:0] SEG_6 = 7'b1011111;
   localparam logic [6:0] SEG_7 = 7'b1110000;
   localparam logic [6:0] SEG_8 = 7'b1111111;
   localparam logic [6:0] SEG_9 = 7'b1111011;
   localparam logic [6:0] SEG_A = 7'b1110111;
   localparam logic [6:0] SEG_B = 7'b0011111;
   localparam logic [6:0] SEG_C = 7'b1001110;
   localparam logic [6:0] SEG_D = 7'b0111101;
   localparam logic [6:0] SEG_E = 7'b1001111;
   localparam logic [6:0] SEG_F = 7'b1000111;

   typedef enum logic [1:0] {
      ST_WAIT,
      ST_SETTLE,
      ST_HOLD
   } cap_state_e;

endpackage

// File: rtl/seg_pattern_lookup.sv
// Reverse lookup from a seven-segment a..g pattern to its hex nibble.
// Unrecognised patterns report hit_o = 0.
module seg_pattern_lookup
   import seg_pkg::*;
(
   input  logic [6:0] pat_i,
   output logic       hit_o,
   output logic [3:0] nib_o
);

   always_comb begin
      hit_o = 1'b1;
      nib_o = 4'h0;
      case (pat_i)
         SEG_0:   nib_o = 4'h0;
         SEG_1:   nib_o = 4'h1;
         SEG_2:   nib_o = 4'h2;
         SEG_3:   nib_o = 4'h3;
         SEG_4:   nib_o = 4'h4;
         SEG_5:   nib_o = 4'h5;
         SEG_6:   nib_o = 4'h6;
         SEG_7:   nib_o = 4'h7;
         SEG_8:   nib_o = 4'h8;
         SEG_9:   nib_o = 4'h9;
         SEG_A:   nib_o = 4'hA;
         SEG_B:   nib_o = 4'hB;
         SEG_C:   nib_o = 4'hC;
         SEG_D:   nib_o = 4'hD;
         SEG_E:   nib_o = 4'hE;
         SEG_F:   nib_o = 4'hF;
         default: hit_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg_capture.sv
// Observer for a multiplexed seven-segment bus: settles, decodes and records
// each lit digit, and emits a one-deep change-event stream.
module seg_capture
   import seg_pkg::*;
#(
   parameter int DIGITS = 8,
   parameter int STABLE = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [7:0]            seg_i,
   input  logic [DIGITS-1:0]     an_i,
   output logic [4*DIGITS-1:0]   digit_o,
   output logic [DIGITS-1:0]     dp_o,
   output logic [DIGITS-1:0]     known_o,
   output logic                  err_o,
   output logic                  ev_valid_o,
   input  logic                  ev_ready_i,
   output logic [2:0]            ev_idx_o,
   output logic [4:0]            ev_val_o,
   output logic                  ovf_o
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [7:0] STABLE_C = 8'(STABLE);

   logic [7:0]              seg_s1_q, seg_s1_d, seg_s_q, seg_s_d;
   logic [DIGITS-1:0]       an_s1_q, an_s1_d, an_s_q, an_s_d;
   logic [7:0]              cnt_q, cnt_d;
   cap_state_e              state_q, state_d;
   logic [DIGITS-1:0][3:0]  digit_q, digit_d;
   logic [DIGITS-1:0]       dp_q, dp_d;
   logic [DIGITS-1:0]       known_q, known_d;
   logic                    err_q, err_d;
   logic                    ev_valid_q, ev_valid_d;
   logic [2:0]              ev_idx_q, ev_idx_d;
   logic [4:0]              ev_val_q, ev_val_d;
   logic                    ovf_q, ovf_d;

   logic                    change;
   logic                    capture;
   logic [3:0]              n_low;
   logic [IW-1:0]           sel;
   logic                    blank;
   logic                    one_hot;
   logic                    hit;
   logic [3:0]              nib;
   logic                    dp;
   logic                    wr;
   logic                    ev_new;
   logic                    pop;

   seg_pattern_lookup u_lookup (
      .pat_i (seg_s_q[7:1]),
      .hit_o (hit),
      .nib_o (nib)
   );

   // change compares the value being loaded into the sample stage
   // against the current sample, so the count tracks the new sample
   always_comb begin
      seg_s1_d = seg_i;
      an_s1_d  = an_i;
      seg_s_d  = seg_s1_q;
      an_s_d   = an_s1_q;
      change   = (seg_s1_q != seg_s_q) || (an_s1_q != an_s_q);
      if (change) begin
         cnt_d = 8'd1;
      end else if (cnt_q >= STABLE_C) begin
         cnt_d = STABLE_C;
      end else begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      unique case (state_q)
         ST_WAIT: begin
            if (change) state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (cnt_d == STABLE_C) begin
               state_d = ST_HOLD;
               capture = 1'b1;
            end
         end
         ST_HOLD: begin
            if (change) state_d = ST_SETTLE;
         end
         default: state_d = ST_SETTLE;
      endcase
   end

   always_comb begin
      n_low = 4'd0;
      sel   = '0;
      for (int k = 0; k < DIGITS; k++) begin
         if (!an_s_q[k]) begin
            n_low = n_low + 4'd1;
            sel   = IW'(k);
         end
      end
      blank   = (n_low == 4'd0);
      one_hot = (n_low == 4'd1);
      dp      = seg_s_q[SEG_DP_BIT];
   end

   always_comb begin
      digit_d = digit_q;
      dp_d    = dp_q;
      known_d = known_q;
      wr      = capture && one_hot && hit;
      err_d   = capture && !blank && (!one_hot || !hit);
      ev_new  = wr && (!known_q[sel] ||
                {dp, nib} != {dp_q[sel], digit_q[sel]});
      if (wr) begin
         digit_d[sel] = nib;
         dp_d[sel]    = dp;
         known_d[sel] = 1'b1;
      end
   end

   // a pop in the same cycle frees the slot for the incoming event
   always_comb begin
      pop        = ev_valid_q && ev_ready_i;
      ev_valid_d = ev_valid_q && !pop;
      ev_idx_d   = ev_idx_q;
      ev_val_d   = ev_val_q;
      ovf_d      = ovf_q;
      if (ev_new) begin
         if (!ev_valid_q || pop) begin
            ev_valid_d = 1'b1;
            ev_idx_d   = 3'(sel);
            ev_val_d   = {dp, nib};
         end else begin
            ovf_d = 1'b1;
         end
      end
   end

   // enables reset to the blank level so reset alone raises no error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_s1_q   <= '0;
         seg_s_q    <= '0;
         an_s1_q    <= '1;
         an_s_q     <= '1;
         cnt_q      <= '0;
         state_q    <= ST_SETTLE;
         digit_q    <= '0;
         dp_q       <= '0;
         known_q    <= '0;
         err_q      <= 1'b0;
         ev_valid_q <= 1'b0;
         ev_idx_q   <= '0;
         ev_val_q   <= '0;
         ovf_q      <= 1'b0;
      end else begin
         seg_s1_q   <= seg_s1_d;
         seg_s_q    <= seg_s_d;
         an_s1_q    <= an_s1_d;
         an_s_q     <= an_s_d;
         cnt_q      <= cnt_d;
         state_q    <= state_d;
         digit_q    <= digit_d;
         dp_q       <= dp_d;
         known_q    <= known_d;
         err_q      <= err_d;
         ev_valid_q <= ev_valid_d;
         ev_idx_q   <= ev_idx_d;
         ev_val_q   <= ev_val_d;
         ovf_q      <= ovf_d;
      end
   end

   assign digit_o    = digit_q;
   assign dp_o       = dp_q;
   assign known_o    = known_q;
   assign err_o      = err_q;
   assign ev_valid_o = ev_valid_q;
   assign ev_idx_o   = ev_idx_q;
   assign ev_val_o   = ev_val_q;
   assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_seg_capture.sv
// Directed testbench for seg_capture with hand-computed expectations.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_seg_capture;

   localparam int DIGITS = 8;
   localparam int STABLE = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  seg_i;
   logic [7:0]  an_i;
   logic [31:0] digit_o;
   logic [7:0]  dp_o;
   logic [7:0]  known_o;
   logic        err_o;
   logic        ev_valid_o;
   logic        ev_ready_i;
   logic [2:0]  ev_idx_o;
   logic [4:0]  ev_val_o;
   logic        ovf_o;

   int n_cmp = 0;
   int n_bad = 0;
   int ev_cnt = 0;
   int err_cnt = 0;

   seg_capture #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .seg_i      (seg_i),
      .an_i       (an_i),
      .digit_o    (digit_o),
      .dp_o       (dp_o),
      .known_o    (known_o),
      .err_o      (err_o),
      .ev_valid_o (ev_valid_o),
      .ev_ready_i (ev_ready_i),
      .ev_idx_o   (ev_idx_o),
      .ev_val_o   (ev_val_o),
      .ovf_o      (ovf_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ev_valid_o && ev_ready_i) ev_cnt++;
      if (err_o) err_cnt++;
   end

   function automatic logic [7:0] seg_of(input int d);
      case (d)
         0: return 8'hFC;
         1: return 8'h60;
         2: return 8'hDA;
         3: return 8'hF2;
         4: return 8'h66;
         5: return 8'hB6;
         6: return 8'hBE;
         7: return 8'hE0;
         8: return 8'hFE;
         default: return 8'hF6;
      endcase
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      an_i = 8'hFF;
      seg_i = 8'h00;
      ev_ready_i = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(STABLE + 3);
   endtask

   task automatic test_reset();
      tick(2);
      n_cmp++;
      if (digit_o !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_digit: got %h want 0", digit_o);
      end
      n_cmp++;
      if ({dp_o, known_o} !== 16'h0) begin
         n_bad++;
         $display("FAIL reset_dp_known: got %h want 0", {dp_o, known_o});
      end
      n_cmp++;
      if ({err_o, ev_valid_o, ev_idx_o, ev_val_o, ovf_o} !== 11'h0) begin
         n_bad++;
         $display("FAIL reset_flags: got %h want 0",
                  {err_o, ev_valid_o, ev_idx_o, ev_val_o, ovf_o});
      end
      rst_n = 1'b1;
      tick(STABLE + 3);
      n_cmp++;
      if ({err_cnt, known_o} !== {32'd0, 8'h00}) begin
         n_bad++;
         $display("FAIL reset_blank_idle: err_cnt %0d known %b want 0/0",
                  err_cnt, known_o);
      end
   endtask

   task automatic test_static();
      int base;
      do_reset();
      base = ev_cnt;
      an_i = 8'hFE;
      seg_i = 8'hDA;
      tick(STABLE);
      n_cmp++;
      if (known_o !== 8'h00 || ev_valid_o !== 1'b0) begin
         n_bad++;
         $display("FAIL static_early: known %b valid %b want 0/0",
                  known_o, ev_valid_o);
      end
      tick(1);
      n_cmp++;
      if (digit_o[3:0] !== 4'h2 || dp_o[0] !== 1'b0) begin
         n_bad++;
         $display("FAIL static_digit: got %h dp %b want 2 dp 0",
                  digit_o[3:0], dp_o[0]);
      end
      n_cmp++;
      if (known_o !== 8'b00000001) begin
         n_bad++;
         $display("FAIL static_known: got %b want 00000001", known_o);
      end
      n_cmp++;
      if ({ev_valid_o, ev_idx_o, ev_val_o} !== {1'b1, 3'd0, 5'h02}) begin
         n_bad++;
         $display("FAIL static_event: got v%b i%0d %h want v1 i0 02",
                  ev_valid_o, ev_idx_o, ev_val_o);
      end
      ev_ready_i = 1'b1;
      tick(1);
      ev_ready_i = 1'b0;
      tick(6);
      n_cmp++;
      if (ev_cnt - base !== 1 || ev_valid_o !== 1'b0) begin
         n_bad++;
         $display("FAIL static_once: events %0d valid %b want 1/0",
                  ev_cnt - base, ev_valid_o);
      end
   endtask

   task automatic test_full_scan();
      int base;
      do_reset();
      ev_ready_i = 1'b1;
      for (int pass = 0; pass < 2; pass++) begin
         base = ev_cnt;
         for (int d = 0; d < 8; d++) begin
            an_i = ~(8'b1 << d);
            seg_i = seg_of(d) | ((d == 3) ? 8'h01 : 8'h00);
            tick(10);
         end
         n_cmp++;
         if (ev_cnt - base !== ((pass == 0) ? 8 : 0)) begin
            n_bad++;
            $display("FAIL scan_events_pass%0d: got %0d want %0d",
                     pass, ev_cnt - base, (pass == 0) ? 8 : 0);
         end
      end
      an_i = 8'hFF;
      seg_i = 8'h00;
      tick(10);
      n_cmp++;
      if (digit_o !== 32'h76543210) begin
         n_bad++;
         $display("FAIL scan_digits: got %h want 76543210", digit_o);
      end
      n_cmp++;
      if (dp_o !== 8'b00001000 || known_o !== 8'hFF) begin
         n_bad++;
         $display("FAIL scan_dp_known: dp %b known %b want 00001000/ff",
                  dp_o, known_o);
      end
      ev_ready_i = 1'b0;
   endtask

   task automatic test_glitch();
      int base_ev;
      int base_err;
      do_reset();
      ev_ready_i = 1'b1;
      an_i = 8'hFE;
      seg_i = seg_of(5);
      tick(10);
      n_cmp++;
      if (digit_o[3:0] !== 4'h5) begin
         n_bad++;
         $display("FAIL glitch_setup: got %h want 5", digit_o[3:0]);
      end
      base_ev = ev_cnt;
      base_err = err_cnt;
      seg_i = seg_of(8);
      tick(2);
      seg_i = seg_of(5);
      tick(12);
      seg_i = seg_of(8);
      tick(STABLE - 1);
      seg_i = seg_of(5);
      tick(12);
      n_cmp++;
      if (digit_o[3:0] !== 4'h5) begin
         n_bad++;
         $display("FAIL glitch_digit: got %h want 5", digit_o[3:0]);
      end
      n_cmp++;
      if (ev_cnt - base_ev !== 0 || err_cnt - base_err !== 0) begin
         n_bad++;
         $display("FAIL glitch_quiet: events %0d errs %0d want 0/0",
                  ev_cnt - base_ev, err_cnt - base_err);
      end
   endtask

   task automatic test_illegal();
      int base_err;
      base_err = err_cnt;
      an_i = 8'hFD;
      seg_i = 8'h02;
      tick(STABLE);
      n_cmp++;
      if (err_o !== 1'b0) begin
         n_bad++;
         $display("FAIL illegal_early: got %b want 0", err_o);
      end
      tick(1);
      n_cmp++;
      if (err_o !== 1'b1) begin
         n_bad++;
         $display("FAIL illegal_pulse: got %b want 1", err_o);
      end
      tick(1);
      n_cmp++;
      if (err_o !== 1'b0) begin
         n_bad++;
         $display("FAIL illegal_pulse_end: got %b want 0", err_o);
      end
      tick(8);
      n_cmp++;
      if (err_cnt - base_err !== 1) begin
         n_bad++;
         $display("FAIL illegal_count: got %0d want 1", err_cnt - base_err);
      end
      n_cmp++;
      if (digit_o[7:4] !== 4'h0 || known_o !== 8'b00000001) begin
         n_bad++;
         $display("FAIL illegal_nowrite: digit1 %h known %b want 0/00000001",
                  digit_o[7:4], known_o);
      end
      base_err = err_cnt;
      an_i = 8'hFC;
      seg_i = seg_of(0);
      tick(12);
      n_cmp++;
      if (err_cnt - base_err !== 1 || known_o !== 8'b00000001) begin
         n_bad++;
         $display("FAIL illegal_an: errs %0d known %b want 1/00000001",
                  err_cnt - base_err, known_o);
      end
      an_i = 8'hFF;
      tick(10);
   endtask

   task automatic test_back_to_back();
      int base;
      do_reset();
      base = ev_cnt;
      an_i = 8'hFE;
      seg_i = seg_of(1);
      tick(10);
      n_cmp++;
      if ({ev_valid_o, ev_val_o} !== {1'b1, 5'h01}) begin
         n_bad++;
         $display("FAIL bp_first: got v%b %h want v1 01",
                  ev_valid_o, ev_val_o);
      end
      seg_i = seg_of(2);
      tick(STABLE);
      ev_ready_i = 1'b1;
      tick(1);
      ev_ready_i = 1'b0;
      n_cmp++;
      if ({ev_valid_o, ev_val_o, ovf_o} !== {1'b1, 5'h02, 1'b0}) begin
         n_bad++;
         $display("FAIL bp_pop_load: got v%b %h ovf %b want v1 02 ovf 0",
                  ev_valid_o, ev_val_o, ovf_o);
      end
      n_cmp++;
      if (ev_cnt - base !== 1) begin
         n_bad++;
         $display("FAIL bp_pop_count: got %0d want 1", ev_cnt - base);
      end
      seg_i = seg_of(3);
      tick(10);
      n_cmp++;
      if ({ev_valid_o, ev_idx_o, ev_val_o, ovf_o} !==
          {1'b1, 3'd0, 5'h02, 1'b1}) begin
         n_bad++;
         $display("FAIL bp_drop: got v%b i%0d %h ovf %b want v1 i0 02 ovf 1",
                  ev_valid_o, ev_idx_o, ev_val_o, ovf_o);
      end
      tick(3);
      n_cmp++;
      if ({ev_valid_o, ev_val_o, digit_o[3:0]} !== {1'b1, 5'h02, 4'h3}) begin
         n_bad++;
         $display("FAIL bp_hold: got v%b %h digit %h want v1 02 3",
                  ev_valid_o, ev_val_o, digit_o[3:0]);
      end
      ev_ready_i = 1'b1;
      tick(1);
      ev_ready_i = 1'b0;
      n_cmp++;
      if (ev_valid_o !== 1'b0 || ovf_o !== 1'b1) begin
         n_bad++;
         $display("FAIL bp_drain: valid %b ovf %b want 0/1",
                  ev_valid_o, ovf_o);
      end
   endtask

   task automatic test_reset_mid();
      int base;
      do_reset();
      an_i = 8'hFE;
      seg_i = seg_of(7);
      tick(10);
      seg_i = seg_of(9);
      tick(2);
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({digit_o, known_o, dp_o} !== 48'h0) begin
         n_bad++;
         $display("FAIL rstmid_regs: digit %h known %b dp %b want 0",
                  digit_o, known_o, dp_o);
      end
      n_cmp++;
      if ({ev_valid_o, ev_idx_o, ev_val_o, ovf_o, err_o} !== 11'h0) begin
         n_bad++;
         $display("FAIL rstmid_event: got v%b i%0d %h ovf %b err %b want 0",
                  ev_valid_o, ev_idx_o, ev_val_o, ovf_o, err_o);
      end
      tick(2);
      rst_n = 1'b1;
      tick(STABLE);
      n_cmp++;
      if (known_o !== 8'h00) begin
         n_bad++;
         $display("FAIL rstmid_early: got %b want 0", known_o);
      end
      tick(1);
      n_cmp++;
      if ({digit_o[3:0], known_o, ev_valid_o, ev_val_o} !==
          {4'h9, 8'h01, 1'b1, 5'h09}) begin
         n_bad++;
         $display("FAIL rstmid_recap: digit %h known %b v%b %h want 9 01 v1 09",
                  digit_o[3:0], known_o, ev_valid_o, ev_val_o);
      end
      base = ev_cnt;
      ev_ready_i = 1'b1;
      tick(20);
      n_cmp++;
      if (ev_cnt - base !== 1) begin
         n_bad++;
         $display("FAIL rstmid_once: got %0d want 1", ev_cnt - base);
      end
      ev_ready_i = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      an_i = 8'hFF;
      seg_i = 8'h00;
      ev_ready_i = 1'b0;
      test_reset();
      test_static();
      test_full_scan();
      test_glitch();
      test_illegal();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
